// File: rtl/key_conditioner.sv
// Per-key synchroniser, tick-based debouncer and press/release/hold pulse generator (hold detector built only with KEY_COND_HOLD_EN).
// Latency: 2 clk sync then DEBOUNCE_TICKS ticks, all outputs registered; no backpressure, paced purely by tick.
module key_conditioner #(
   parameter int N_KEYS         = 4,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int HOLD_TICKS     = 1000,
   parameter int ACTIVE_LOW     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_hold,
   output logic [N_KEYS-1:0] hold_pulse
);

   typedef enum logic [1:0] {
      UP           = 2'd0,
      PRESS_WAIT   = 2'd1,
      DOWN         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [15:0]       DEB_LIM   = 16'(DEBOUNCE_TICKS);
   localparam logic [15:0]       HOLD_LIM  = 16'(HOLD_TICKS);
   // Synchronisers idle at the "not pressed" level so reset never looks like a press.
   localparam logic [N_KEYS-1:0] SYNC_INIT = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

   logic [N_KEYS-1:0] sync_q1;
   logic [N_KEYS-1:0] sync_q2;
   logic [N_KEYS-1:0] s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q1 <= SYNC_INIT;
         sync_q2 <= SYNC_INIT;
      end else begin
         sync_q1 <= key_raw;
         sync_q2 <= sync_q1;
      end
   end

   assign s = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      state_t      state;
      state_t      state_nxt;
      logic [15:0] cnt;
      logic [15:0] cnt_nxt;
      logic        press_nxt;
      logic        release_nxt;
      logic        level_q;
      logic        press_q;
      logic        release_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state     <= UP;
            cnt       <= 16'd0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_q   <= (state_nxt == DOWN) || (state_nxt == RELEASE_WAIT);
            press_q   <= press_nxt;
            release_q <= release_nxt;
         end
      end

      // A bounce takes priority over a coincident tick: the attempt restarts from zero.
      always_comb begin
         state_nxt   = state;
         cnt_nxt     = cnt;
         press_nxt   = 1'b0;
         release_nxt = 1'b0;
         case (state)
            UP: begin
               if (s[i]) begin
                  state_nxt = PRESS_WAIT;
                  cnt_nxt   = 16'd0;
               end
            end
            PRESS_WAIT: begin
               if (!s[i]) begin
                  state_nxt = UP;
                  cnt_nxt   = 16'd0;
               end else if (tick) begin
                  if (cnt + 16'd1 == DEB_LIM) begin
                     state_nxt = DOWN;
                     cnt_nxt   = 16'd0;
                     press_nxt = 1'b1;
                  end else begin
                     cnt_nxt = cnt + 16'd1;
                  end
               end
            end
            DOWN: begin
               if (!s[i]) begin
                  state_nxt = RELEASE_WAIT;
                  cnt_nxt   = 16'd0;
               end
            end
            RELEASE_WAIT: begin
               if (s[i]) begin
                  state_nxt = DOWN;
                  cnt_nxt   = 16'd0;
               end else if (tick) begin
                  if (cnt + 16'd1 == DEB_LIM) begin
                     state_nxt   = UP;
                     cnt_nxt     = 16'd0;
                     release_nxt = 1'b1;
                  end else begin
                     cnt_nxt = cnt + 16'd1;
                  end
               end
            end
            default: begin
               state_nxt = UP;
               cnt_nxt   = 16'd0;
            end
         endcase
      end

      assign key_level[i]   = level_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;

`ifdef KEY_COND_HOLD_EN
      logic [15:0] hold_cnt;
      logic        hold_q;
      logic        hpulse_q;
      logic        held;

      assign held = (state == DOWN) || (state == RELEASE_WAIT);

      // Completing a release wins over a hold that would land on the same tick.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            hold_cnt <= 16'd0;
            hold_q   <= 1'b0;
            hpulse_q <= 1'b0;
         end else if (release_nxt) begin
            hold_cnt <= 16'd0;
            hold_q   <= 1'b0;
            hpulse_q <= 1'b0;
         end else begin
            hpulse_q <= 1'b0;
            if (held && tick && (hold_cnt != HOLD_LIM)) begin
               hold_cnt <= hold_cnt + 16'd1;
               if (hold_cnt + 16'd1 == HOLD_LIM) begin
                  hold_q   <= 1'b1;
                  hpulse_q <= 1'b1;
               end
            end
         end
      end

      assign key_hold[i]   = hold_q;
      assign hold_pulse[i] = hpulse_q;
`else
      assign key_hold[i]   = 1'b0;
      assign hold_pulse[i] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: pulses are scoreboarded against expected edges, levels checked inline.
// Tick fires on every posedge whose index is a multiple of 5.
module tb_key_conditioner;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic [3:0] key_raw = 4'hF;
   logic [3:0] key_level;
   logic [3:0] key_press;
   logic [3:0] key_release;
   logic [3:0] key_hold;
   logic [3:0] hold_pulse;

   int pe = 0;
   int n_assert = 0;
   int n_fail = 0;

   typedef struct {
      int         e;
      logic [3:0] p;
      logic [3:0] r;
      logic [3:0] h;
   } exp_t;

   exp_t sb[$];

   key_conditioner #(
      .N_KEYS(4),
      .DEBOUNCE_TICKS(4),
      .HOLD_TICKS(10),
      .ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .key_raw(key_raw),
      .key_level(key_level),
      .key_press(key_press),
      .key_release(key_release),
      .key_hold(key_hold),
      .hold_pulse(hold_pulse)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) pe <= pe + 1;

   initial forever begin
      @(negedge clk);
      tick = ((pe + 1) % 5 == 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Index of the n-th tick edge strictly after edge 'after'.
   function automatic int nth_tick(input int after, input int n);
      return (after / 5 + n) * 5;
   endfunction

   task automatic push(input int e, input logic [3:0] p, input logic [3:0] r, input logic [3:0] h);
      exp_t x;
      x.e = e;
      x.p = p;
      x.r = r;
      x.h = h;
      sb.push_back(x);
   endtask

   task automatic wait_edge(input int e);
      while (pe < e) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Returns the index of the first posedge that samples the new value.
   task automatic drive(input logic [3:0] v, output int p);
      @(negedge clk);
      key_raw = v;
      p = pe + 1;
   endtask

   initial forever begin
      exp_t x;
      @(posedge clk);
      #2;
      if ((key_press | key_release | hold_pulse) != 4'h0) begin
         check("press_release_excl", 32'(key_press & key_release), 32'h0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'({key_press, key_release, hold_pulse}), 32'h0);
         end else begin
            x = sb.pop_front();
            check("pulse_edge", pe, x.e);
            check("pulse_press", 32'(key_press), 32'(x.p));
            check("pulse_release", 32'(key_release), 32'(x.r));
            check("pulse_hold", 32'(hold_pulse), 32'(x.h));
         end
      end
   end

   initial begin
      int         p;
      int         t3;
      int         t4;
      int         e;
      int         r;
      int         he;
      logic [3:0] hexp;

      rst = 1'b0;
      key_raw = 4'hF;
      repeat (3) @(posedge clk);
      #2;
      check("rst_level", 32'(key_level), 32'h0);
      check("rst_press", 32'(key_press), 32'h0);
      check("rst_release", 32'(key_release), 32'h0);
      check("rst_hold", 32'(key_hold), 32'h0);
      check("rst_hold_pulse", 32'(hold_pulse), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      wait_edge(pe + 10);
      check("idle_level", 32'(key_level), 32'h0);
      check("idle_hold", 32'(key_hold), 32'h0);

      // Reset in the middle of a press attempt, key kept down across reset
      drive(4'b1110, p);
      wait_edge(nth_tick(p + 2, 2));
      @(negedge clk);
      rst = 1'b0;
      wait_edge(pe + 3);
      check("mid_rst_level", 32'(key_level), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      p = pe + 1;
      e = nth_tick(p + 2, 4);
      push(e, 4'b0001, 4'h0, 4'h0);
      wait_edge(e - 1);
      check("press0_before", 32'(key_level), 32'h0);
      wait_edge(e);
      check("press0_level", 32'(key_level), 32'h1);

      drive(4'hF, p);
      e = nth_tick(p + 2, 4);
      push(e, 4'h0, 4'b0001, 4'h0);
      wait_edge(e - 1);
      check("release0_before", 32'(key_level), 32'h1);
      wait_edge(e);
      check("release0_level", 32'(key_level), 32'h0);

      // Bounce on key 1 after three counted ticks
      drive(4'b1101, p);
      t3 = nth_tick(p + 2, 3);
      wait_edge(t3);
      drive(4'hF, p);
      drive(4'b1101, p);
      e = nth_tick(p + 2, 4);
      push(e, 4'b0010, 4'h0, 4'h0);
      wait_edge(t3 + 5);
      check("bounce_no_early", 32'(key_level), 32'h0);
      wait_edge(e - 1);
      check("bounce_before", 32'(key_level), 32'h0);
      wait_edge(e);
      check("bounce_press", 32'(key_level), 32'h2);
      drive(4'hF, p);
      e = nth_tick(p + 2, 4);
      push(e, 4'h0, 4'b0010, 4'h0);
      wait_edge(e);
      check("bounce_release", 32'(key_level), 32'h0);

      // Key 3 bounces back on exactly the tick that would complete the debounce
      drive(4'b0111, p);
      t4 = nth_tick(p + 2, 4);
      wait_edge(t4 - 3);
      drive(4'hF, p);
      drive(4'b0111, p);
      e = nth_tick(p + 2, 4);
      push(e, 4'b1000, 4'h0, 4'h0);
      wait_edge(t4 + 1);
      check("collision_no_press", 32'(key_level), 32'h0);
      wait_edge(e);
      check("collision_press", 32'(key_level), 32'h8);
      drive(4'hF, p);
      e = nth_tick(p + 2, 4);
      push(e, 4'h0, 4'b1000, 4'h0);
      wait_edge(e);
      check("collision_release", 32'(key_level), 32'h0);

      // Keys 0 and 3 together
      drive(4'b0110, p);
      e = nth_tick(p + 2, 4);
      push(e, 4'b1001, 4'h0, 4'h0);
      wait_edge(e);
      check("indep_press", 32'(key_level), 32'h9);
      drive(4'hF, p);
      e = nth_tick(p + 2, 4);
      push(e, 4'h0, 4'b1001, 4'h0);
      wait_edge(e);
      check("indep_release", 32'(key_level), 32'h0);

      // Long hold on key 2
      drive(4'b1011, p);
      e = nth_tick(p + 2, 4);
      he = nth_tick(e, 10);
      push(e, 4'b0100, 4'h0, 4'h0);
`ifdef KEY_COND_HOLD_EN
      hexp = 4'b0100;
      push(he, 4'h0, 4'h0, 4'b0100);
`else
      hexp = 4'b0000;
`endif
      wait_edge(he - 1);
      check("hold_before", 32'(key_hold), 32'h0);
      wait_edge(he);
      check("hold_on", 32'(key_hold), 32'(hexp));
      wait_edge(nth_tick(e, 12));
      check("hold_keep", 32'(key_hold), 32'(hexp));
      drive(4'hF, p);
      r = nth_tick(p + 2, 4);
      push(r, 4'h0, 4'b0100, 4'h0);
      wait_edge(r - 1);
      check("hold_rw_hold", 32'(key_hold), 32'(hexp));
      check("hold_rw_level", 32'(key_level), 32'h4);
      wait_edge(r);
      check("hold_cleared", 32'(key_hold), 32'h0);
      check("hold_released", 32'(key_level), 32'h0);

      wait_edge(pe + 10);
      check("sb_empty", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
